sr_comparator_bank: RTL
=======================

# sr_comparator_bank

Multi-channel set/reset comparator bank: each of CHANNELS outputs is driven high when the shared position counter equals that channel's set value and low when it equals its reset value. Per-channel compare values are written through a shadow register file and committed to the active compare registers atomically on an update strobe, so a channel pair never takes effect half-written. The bank sits downstream of the angle/position counter and drives the channel output pins (ignition/injection style pulse windows).

## Interface
Parameters:
- WIDTH, 24, width of compare values and position counter
- CHANNELS, 4, number of independent output channels (1..16)
- CH_W, $clog2(CHANNELS) (min 1), width of channel select

Ports:
- clk  in  1  system clock, all logic rising-edge
- arst_n  in  1  asynchronous active-low reset
- data_compare  in  WIDTH  current position counter value
- cmp_ena  in  1  compare qualifier; compares evaluated only when high
- wr_en  in  1  shadow write strobe
- wr_ch  in  CH_W  channel index for write
- wr_set  in  WIDTH  set value for write
- wr_reset  in  WIDTH  reset value for write
- update  in  1  commit all pending shadows to active registers
- ch_en  in  CHANNELS  per-channel enable
- out_clr  in  1  synchronous clear of all outputs
- out  out  CHANNELS  registered channel outputs
- pending  out  CHANNELS  shadow written, not yet committed
- armed  out  CHANNELS  channel has committed values
- set_evt  out  CHANNELS  one-cycle pulse, out rose this cycle
- reset_evt  out  CHANNELS  one-cycle pulse, out fell this cycle

## Operation
- Reset (arst_n low, asynchronous): all shadow/active registers 0, pending 0, armed 0, out 0, set_evt/reset_evt 0.
- Write: wr_en high and wr_ch < CHANNELS → shadow_set/shadow_reset[wr_ch] loaded, pending[wr_ch] set. wr_ch ≥ CHANNELS: ignored, no state change. A repeated write before update overwrites the shadow.
- Update: for every channel with pending=1, active ← shadow, armed ← 1, pending ← 0. Non-pending channels keep active values.
- Write and update same cycle: update commits the shadow contents from before the edge; the new write lands in the shadow and pending stays 1 for that channel.
- Compare (per channel, only when cmp_ena=1, ch_en=1, armed=1): set_hit = (data_compare == act_set), reset_hit = (data_compare == act_reset).
  - out=0 and set_hit → out ← 1, set_evt pulse.
  - out=1 and reset_hit → out ← 0, reset_evt pulse.
  - act_set == act_reset: a hit toggles nothing in the same cycle beyond the rule above (out=0 sets, then the next matching compare resets).
- Priority, highest first: arst_n, out_clr (all out ← 0, no evt pulses), ch_en[i]=0 (out[i] ← 0, no pulse), compare rule.
- Update does not change out; a channel re-armed mid-pulse remains high until its new reset value matches.
- Counter wrap: pure equality, no ordering assumption; set > reset is a legal wrapping window.

## Timing
- Compare latency: data_compare sampled at edge N (cmp_ena high) → out/evt valid after edge N, i.e. one register stage.
- Values committed by update at edge N are used for compares from edge N+1.
- pending reflects a write the cycle after wr_en; armed the cycle after update.
- set_evt/reset_evt are high exactly one cycle per transition, aligned with the out change.
- cmp_ena low: out holds, no evt.

## Configuration
- RANGE_COMPARE_EN defined: per channel, out is registered as the window test armed & ch_en & (act_set ≤ act_reset ? (act_set ≤ data_compare < act_reset) : (data_compare ≥ act_set | data_compare < act_reset)), evaluated when cmp_ena=1; act_set == act_reset → out 0. Robust to a counter that skips values. evt pulses still mark out edges; out_clr priority unchanged.
- Not defined: equality set/reset edge behaviour described in Operation.

## Test plan
- Reset: arst_n low mid-pulse with out=4'b0101 → out, pending, armed all 0 immediately, no evt.
- Basic window: ch0 set=10, reset=20, update; sweep data_compare 0..30 with cmp_ena=1 → out[0] rises after edge sampling 10, falls after edge sampling 20, one set_evt and one reset_evt.
- Atomic commit: ch1 active 100/200, write 300/400 while counter at 150 with out[1]=1, no update → out[1] falls at 200; update then → next rise at 300.
- Write+update same cycle: pending ch2 shadow 5/6, write 50/60 on the update edge → active=5/6, pending[2]=1, second update → active=50/60.
- Wrap and priority: ch3 set=0xFFFFF0, reset=0x000010, counter wraps → out[3] high across wrap; out_clr at 0x000005 → out[3]=0, no reset_evt; wr_ch=CHANNELS ignored.
- RANGE_COMPARE_EN: ch0 10/20, counter steps by 7 (0,7,14,21) → out[0] high only at sample 14.

Source files
------------

// File: rtl/sr_comparator_bank.sv
// Set/reset comparator bank: per-channel shadow compare registers committed atomically on update.
// Optional build macro RANGE_COMPARE_EN: out becomes a window test instead of equality set/reset edges.

module sr_cmp_lane #(
   parameter int WIDTH = 24
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_cmp_ena,
   input  logic             i_ch_en,
   input  logic             i_out_clr,
   input  logic             i_wr_hit,
   input  logic [WIDTH-1:0] i_wr_set,
   input  logic [WIDTH-1:0] i_wr_reset,
   input  logic             i_update,
   output logic             o_out,
   output logic             o_pending,
   output logic             o_armed,
   output logic             o_set_evt,
   output logic             o_reset_evt
);
   logic [WIDTH-1:0] r_sh_set, r_sh_rst, r_act_set, r_act_rst;
   logic             r_pending, r_armed, r_out, r_set_evt, r_reset_evt;

   // Update commits the pre-edge shadow; a same-cycle write re-arms pending.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_sh_set  <= '0;
         r_sh_rst  <= '0;
         r_act_set <= '0;
         r_act_rst <= '0;
         r_pending <= 1'b0;
         r_armed   <= 1'b0;
      end else begin
         if (i_wr_hit) begin
            r_sh_set <= i_wr_set;
            r_sh_rst <= i_wr_reset;
         end
         if (i_update && r_pending) begin
            r_act_set <= r_sh_set;
            r_act_rst <= r_sh_rst;
            r_armed   <= 1'b1;
         end
         if (i_wr_hit)
            r_pending <= 1'b1;
         else if (i_update)
            r_pending <= 1'b0;
      end
   end

`ifdef RANGE_COMPARE_EN
   logic w_win;
   // set > reset is a window that wraps through zero; set == reset is an empty window.
   always_comb begin
      w_win = 1'b0;
      if (r_act_set <= r_act_rst)
         w_win = (i_data >= r_act_set) && (i_data < r_act_rst);
      else
         w_win = (i_data >= r_act_set) || (i_data < r_act_rst);
      w_win = w_win & r_armed;
   end
`else
   logic w_set_hit, w_rst_hit;
   assign w_set_hit = (i_data == r_act_set);
   assign w_rst_hit = (i_data == r_act_rst);
`endif

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_out       <= 1'b0;
         r_set_evt   <= 1'b0;
         r_reset_evt <= 1'b0;
      end else begin
         r_set_evt   <= 1'b0;
         r_reset_evt <= 1'b0;
         if (i_out_clr || !i_ch_en) begin
            r_out <= 1'b0;
         end else if (i_cmp_ena) begin
`ifdef RANGE_COMPARE_EN
            r_out       <= w_win;
            r_set_evt   <= w_win & ~r_out;
            r_reset_evt <= ~w_win & r_out;
`else
            if (r_armed) begin
               if (!r_out && w_set_hit) begin
                  r_out     <= 1'b1;
                  r_set_evt <= 1'b1;
               end else if (r_out && w_rst_hit) begin
                  r_out       <= 1'b0;
                  r_reset_evt <= 1'b1;
               end
            end
`endif
         end
      end
   end

   assign o_out       = r_out;
   assign o_pending   = r_pending;
   assign o_armed     = r_armed;
   assign o_set_evt   = r_set_evt;
   assign o_reset_evt = r_reset_evt;
endmodule

module sr_comparator_bank #(
   parameter int WIDTH    = 24,
   parameter int CHANNELS = 4,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic [WIDTH-1:0]    data_compare,
   input  logic                cmp_ena,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [WIDTH-1:0]    wr_set,
   input  logic [WIDTH-1:0]    wr_reset,
   input  logic                update,
   input  logic [CHANNELS-1:0] ch_en,
   input  logic                out_clr,
   output logic [CHANNELS-1:0] out,
   output logic [CHANNELS-1:0] pending,
   output logic [CHANNELS-1:0] armed,
   output logic [CHANNELS-1:0] set_evt,
   output logic [CHANNELS-1:0] reset_evt
);
   logic [CHANNELS-1:0] w_wr_hit;

   // Per-channel decode; an out-of-range wr_ch matches no lane and is dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      assign w_wr_hit[i] = wr_en && (wr_ch == CH_W'(i));

      sr_cmp_lane #(.WIDTH(WIDTH)) u_lane (
         .clk         (clk),
         .arst_n      (arst_n),
         .i_data      (data_compare),
         .i_cmp_ena   (cmp_ena),
         .i_ch_en     (ch_en[i]),
         .i_out_clr   (out_clr),
         .i_wr_hit    (w_wr_hit[i]),
         .i_wr_set    (wr_set),
         .i_wr_reset  (wr_reset),
         .i_update    (update),
         .o_out       (out[i]),
         .o_pending   (pending[i]),
         .o_armed     (armed[i]),
         .o_set_evt   (set_evt[i]),
         .o_reset_evt (reset_evt[i])
      );
   end
endmodule
